// File: rtl/btn_debounce.sv
// Two-channel push-button debouncer: 2-flop synchronizer, then a stability FSM per bit.
// Level changes L+2 edges after a stable raw change; press/release are registered one-cycle pulses.
module btn_debounce #(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int TURBO_CNT    = 1_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       turbosim,
  input  logic [1:0] buttons,
  output logic [1:0] btn_level,
  output logic [1:0] btn_press,
  output logic [1:0] btn_release
);

  localparam int MAXC = (DEBOUNCE_CNT > TURBO_CNT) ? DEBOUNCE_CNT : TURBO_CNT;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} state_e;

  logic [1:0]    sync1_q, sync2_q;
  state_e        state_q [2];
  state_e        state_d [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];
  logic [1:0]    press_q, press_d;
  logic [1:0]    rel_q, rel_d;
  logic [CW-1:0] lim_m1;

  // Limit is re-evaluated every cycle; the >= compare lets a shrinking limit finish at once.
  assign lim_m1 = turbosim ? CW'(TURBO_CNT - 1) : CW'(DEBOUNCE_CNT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      press_q <= 2'b00;
      rel_q   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= LOW;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    press_d = 2'b00;
    rel_d   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      case (state_q[i])
        LOW: begin
          if (sync2_q[i]) begin
            state_d[i] = RISE_WAIT;
            cnt_d[i]   = CW'(1);
          end
        end
        RISE_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = LOW;
          end else if (cnt_q[i] >= lim_m1) begin
            state_d[i] = HIGH;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        HIGH: begin
          if (!sync2_q[i]) begin
            state_d[i] = FALL_WAIT;
            cnt_d[i]   = CW'(1);
          end
        end
        FALL_WAIT: begin
          if (sync2_q[i]) begin
            state_d[i] = HIGH;
          end else if (cnt_q[i] >= lim_m1) begin
            state_d[i] = LOW;
            rel_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = LOW;
        end
      endcase
    end
  end

  always_comb begin
    btn_level = 2'b00;
    for (int i = 0; i < 2; i++) begin
      btn_level[i] = (state_q[i] == HIGH) || (state_q[i] == FALL_WAIT);
    end
  end

  assign btn_press   = press_q;
  assign btn_release = rel_q;

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 1_000_000, stable-cycle count when turbosim=0 (10 ms at 100 MHz).
REQ-002 Parameter TURBO_CNT, default 1_000, stable-cycle count when turbosim=1 (10 us at 100 MHz); both parameters >= 2.
REQ-003 clk  input  1  system clock, 100 MHz, all flops on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 turbosim  input  1  selects TURBO_CNT (1) or DEBOUNCE_CNT (0) as active limit L.
REQ-006 buttons  input  2  raw asynchronous push-buttons {L,R}, active-high.
REQ-007 btn_level  output  2  debounced button levels {L,R}.
REQ-008 btn_press  output  2  one-cycle pulse per bit on debounced 0->1.
REQ-009 btn_release  output  2  one-cycle pulse per bit on debounced 1->0.

Function
REQ-010 Each bit SHALL be processed by an independent, identical channel; no channel state depends on the other bit.
REQ-011 Each channel SHALL pass its raw input through a 2-flop synchronizer; s denotes the second-flop output.
REQ-012 Each channel SHALL hold a 4-state FSM: LOW, RISE_WAIT, HIGH, FALL_WAIT; btn_level=1 in HIGH and FALL_WAIT only.
REQ-013 Each channel SHALL hold a stability counter wide enough for max(DEBOUNCE_CNT, TURBO_CNT)-1, no wrap.
REQ-014 LOW: s=1 -> RISE_WAIT, counter=1; else stay, counter=0.
REQ-015 RISE_WAIT: s=0 -> LOW, counter=0; s=1 and counter>=L-1 -> HIGH, counter=0, btn_press pulse; else counter+1.
REQ-016 HIGH: s=0 -> FALL_WAIT, counter=1; else stay, counter=0.
REQ-017 FALL_WAIT: s=1 -> HIGH, counter=0; s=0 and counter>=L-1 -> LOW, counter=0, btn_release pulse; else counter+1.
REQ-018 Latency: raw change first sampled at edge E, held stable -> btn_level changes at edge E+L+1 (L+2 cycles including E).
REQ-019 btn_press/btn_release SHALL be registered, asserted in the same cycle btn_level changes, deasserted on the next edge.
REQ-020 Any bounce shorter than L consecutive stable s-cycles SHALL produce no change on any output.
REQ-021 turbosim is sampled every cycle; the >= comparison guarantees completion if L shrinks mid-count (transition on the next edge).
REQ-022 Simultaneous stable changes on both bits SHALL produce both pulses in the same cycle.
REQ-023 btn_press and btn_release for one bit SHALL never be asserted together; no pulse in a cycle without a level change.

Reset
REQ-024 While reset=1: synchronizer flops=0, FSM=LOW, counters=0, btn_level=2'b00, btn_press=2'b00, btn_release=2'b00.
REQ-025 Reset asserted mid-count SHALL abandon the count; a button held through reset release needs a full L+2 cycles from the first post-reset sampling edge, then produces btn_press.
REQ-026 No output pulse SHALL be produced by reset assertion or deassertion alone.

Verification
REQ-027 Reset: reset=1 at t=0 with buttons=2'b11 -> all outputs 0 throughout reset; after release, btn_level=2'b11 exactly TURBO_CNT+2 cycles later.
REQ-028 Clean press, turbosim=1: buttons 00->10 held -> btn_level[1] rises at cycle 1002, btn_press=2'b10 for exactly one cycle, bit 0 outputs stay 0.
REQ-029 Bounce: buttons[1] high 500 cycles, low 3 cycles, high again -> no press before 1002 cycles after the final rise; exactly one btn_press[1].
REQ-030 Release and simultaneity: buttons 11->00 from HIGH -> btn_release=2'b11 in one cycle, btn_level=2'b00 at cycle 1002.
REQ-031 Turbo off: turbosim=0, buttons[0] 0->1 -> btn_level[0] rises at cycle 1_000_002, not earlier.
REQ-032 Mid-count switch: turbosim=0, press held 5_000 cycles, then turbosim=1 -> HIGH and btn_press on the next edge.
